// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, buffer entry layout
// and the default buffer depth.
package fetch_unit_pkg;

   localparam int FETCH_BUF_DEPTH = 2;

   typedef enum logic {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} entries between instruction memory and the decoder.
// Flush empties it in one cycle; a push into a full buffer only lands if the head pops.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter  int DEPTH = FETCH_BUF_DEPTH,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word request at a time to
// instruction memory and queues the returned words for the decoder.
//
//   state  | meaning
//   S_REQ  | request pc when the buffer has room (counting a same-cycle pop)
//   S_WAIT | one request outstanding; its word is pushed unless killed
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   input  logic        if_ready_i,
   output logic        misaligned_o
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   pc;
   logic [31:0]   req_pc;
   logic [31:0]   target;
   logic          kill;
   logic          pop;
   logic          push;
   logic          granted;
   logic          buf_empty;
   logic [CW-1:0] buf_count;
   logic [CW-1:0] credit_count;
   fetch_entry_t  head;

   assign target       = word_align(redirect_pc_i);
   assign pop          = if_valid_o && if_ready_i;
   assign credit_count = pop ? buf_count - CW'(1) : buf_count;
   assign imem_req_o   = !rst && (state == S_REQ) && (credit_count < CW'(BUF_DEPTH));
   assign imem_addr_o  = pc;
   assign granted      = imem_req_o && imem_gnt_i;
   assign push         = (state == S_WAIT) && imem_rvalid_i && !kill && !redirect_i;

   assign if_valid_o   = !buf_empty;
   assign if_instr_o   = buf_empty ? '0 : head.instr;
   assign if_pc_o      = buf_empty ? '0 : head.pc;

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_i),
      .push      (push),
      .push_data ('{pc: req_pc, instr: imem_rdata_i}),
      .pop       (pop),
      .head      (head),
      .count     (buf_count),
      .empty     (buf_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_REQ;
         pc           <= RESET_PC;
         req_pc       <= RESET_PC;
         kill         <= 1'b0;
         misaligned_o <= 1'b0;
      end else begin
         misaligned_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
         case (state)
            S_REQ: begin
               if (redirect_i) begin
                  pc <= target;
                  // the granted request still returns a word; it must be thrown away
                  if (granted) begin
                     kill  <= 1'b1;
                     state <= S_WAIT;
                  end
               end else if (granted) begin
                  req_pc <= pc;
                  pc     <= pc + 32'd4;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  state <= S_REQ;
                  kill  <= 1'b0;
                  if (redirect_i) pc <= target;
               end else if (redirect_i) begin
                  kill <= 1'b1;
                  pc   <= target;
               end
            end
         endcase
      end
   end

   // A response with nothing outstanding is a memory-side protocol error; the FSM ignores it.
   a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid_i |-> (state == S_WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model, per-cycle trace of
// the DUT outputs, and hand-computed expectations checked after each scenario.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic        if_ready_i = 1'b1;
   logic        misaligned_o;

   fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .if_valid_o    (if_valid_o),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_ready_i    (if_ready_i),
      .misaligned_o  (misaligned_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // memory model state
   int          lat = 1;
   logic        gnt_en = 1'b1;
   logic        pend = 1'b0;
   int          pend_wait = 0;
   logic [31:0] pend_addr = '0;

   // per-cycle trace and event logs
   int          cyc;
   logic [31:0] obs_addr  [64];
   logic [31:0] obs_pc    [64];
   logic        obs_req   [64];
   logic        obs_valid [64];
   logic        obs_mis   [64];
   int          n_cons;
   logic [31:0] cons_pc    [16];
   logic [31:0] cons_instr [16];
   int          cons_cyc   [16];
   int          n_gnt;
   logic [31:0] gnt_addr [16];
   int          gnt_cyc  [16];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic clear_trace();
      cyc    = 0;
      n_cons = 0;
      n_gnt  = 0;
      for (int i = 0; i < 64; i++) begin
         obs_addr[i] = 32'hBAD0_BAD0; obs_pc[i] = 32'hBAD0_BAD0;
         obs_req[i] = 1'bx; obs_valid[i] = 1'bx; obs_mis[i] = 1'bx;
      end
      for (int i = 0; i < 16; i++) begin
         cons_pc[i] = 32'hBAD0_BAD0; cons_instr[i] = 32'hBAD0_BAD0; cons_cyc[i] = -1;
         gnt_addr[i] = 32'hBAD0_BAD0; gnt_cyc[i] = -1;
      end
   endtask

   // Entered and left at a falling edge; caller has already set ready/redirect/gnt_en.
   task automatic run_cycle();
      logic [31:0] a;
      imem_rvalid_i = pend && (pend_wait == 0);
      imem_rdata_i  = imem_rvalid_i ? mem_word(pend_addr) : 32'h0;
      #1;
      imem_gnt_i = gnt_en && imem_req_o;
      a = imem_addr_o;
      #1;
      if (cyc < 64) begin
         obs_addr[cyc] = imem_addr_o; obs_pc[cyc] = if_pc_o; obs_req[cyc] = imem_req_o;
         obs_valid[cyc] = if_valid_o; obs_mis[cyc] = misaligned_o;
      end
      if (if_valid_o && if_ready_i && n_cons < 16) begin
         cons_pc[n_cons] = if_pc_o; cons_instr[n_cons] = if_instr_o; cons_cyc[n_cons] = cyc;
         n_cons++;
      end
      if (imem_gnt_i && n_gnt < 16) begin
         gnt_addr[n_gnt] = a; gnt_cyc[n_gnt] = cyc;
         n_gnt++;
      end
      @(posedge clk);
      if (imem_rvalid_i) pend = 1'b0;
      else if (pend) pend_wait--;
      if (imem_gnt_i) begin
         pend = 1'b1; pend_wait = lat - 1; pend_addr = a;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b1;
      gnt_en = 1'b1; lat = 1; pend = 1'b0; pend_wait = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_req",   32'(imem_req_o),   32'd0);
      chk("rst_valid", 32'(if_valid_o),   32'd0);
      chk("rst_mis",   32'(misaligned_o), 32'd0);
      chk("rst_addr",  imem_addr_o,       32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_trace();
   endtask

   initial begin
      int k;

      // 1: streaming with 1-cycle memory
      do_reset();
      repeat (9) run_cycle();
      chk("t1_first_req", 32'(obs_req[0]), 32'd1);
      chk("t1_valid_rvalid_cyc", 32'(obs_valid[1]), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("t1_pc",    cons_pc[i],        32'(4 * i));
         chk("t1_instr", cons_instr[i],     mem_word(32'(4 * i)));
         chk("t1_cyc",   32'(cons_cyc[i]),  32'(2 + 2 * i));
      end

      // 2: decoder stalls, buffer fills, then drains in order
      do_reset();
      if_ready_i = 1'b0;
      repeat (10) run_cycle();
      if_ready_i = 1'b1;
      repeat (4) run_cycle();
      k = 0;
      for (int i = 0; i < n_gnt; i++) if (gnt_cyc[i] < 10) k++;
      chk("t2_grants_while_stalled", 32'(k), 32'd2);
      chk("t2_req_full",    32'(obs_req[9]),   32'd0);
      chk("t2_valid_full",  32'(obs_valid[9]), 32'd1);
      chk("t2_head_full",   obs_pc[9],         32'h0);
      chk("t2_req_on_pop",  32'(obs_req[10]),  32'd1);
      chk("t2_pc0",         cons_pc[0],        32'h0);
      chk("t2_pc1",         cons_pc[1],        32'h4);
      chk("t2_pc0_cyc",     32'(cons_cyc[0]),  32'd10);

      // 3: redirect while the 0x8 response is outstanding
      do_reset();
      lat = 2;
      repeat (7) run_cycle();
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      run_cycle();
      redirect_i = 1'b0;
      repeat (7) run_cycle();
      chk("t3_gnt8",     gnt_addr[2],   32'h8);
      chk("t3_n_cons",   32'(n_cons),   32'd3);
      chk("t3_pc1",      cons_pc[1],    32'h4);
      chk("t3_pc2",      cons_pc[2],    32'h100);
      chk("t3_instr2",   cons_instr[2], mem_word(32'h100));
      chk("t3_req_kill", 32'(obs_req[8]), 32'd0);
      chk("t3_addr_new", obs_addr[9],   32'h100);

      // 4: redirect with a same-cycle grant, then with a same-cycle response
      do_reset();
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      run_cycle();
      redirect_i = 1'b0;
      repeat (4) run_cycle();
      redirect_i = 1'b1; redirect_pc_i = 32'h80;
      run_cycle();
      redirect_i = 1'b0;
      repeat (4) run_cycle();
      chk("t4_n_cons",   32'(n_cons),      32'd2);
      chk("t4_pc0",      cons_pc[0],       32'h40);
      chk("t4_pc1",      cons_pc[1],       32'h80);
      chk("t4_instr1",   cons_instr[1],    mem_word(32'h80));
      chk("t4_dropped",  32'(obs_valid[6]), 32'd0);
      chk("t4_gnt_new",  gnt_addr[3],      32'h80);
      chk("t4_mis_none", 32'(obs_mis[1]),  32'd0);

      // 5: misaligned redirect while the request is held ungranted
      do_reset();
      gnt_en = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h203;
      run_cycle();
      redirect_i = 1'b0;
      run_cycle();
      gnt_en = 1'b1;
      repeat (4) run_cycle();
      chk("t5_mis0",   32'(obs_mis[0]), 32'd0);
      chk("t5_mis1",   32'(obs_mis[1]), 32'd1);
      chk("t5_mis2",   32'(obs_mis[2]), 32'd0);
      chk("t5_addr0",  obs_addr[0],     32'h0);
      chk("t5_addr1",  obs_addr[1],     32'h200);
      chk("t5_req1",   32'(obs_req[1]), 32'd1);
      chk("t5_gnt",    gnt_addr[0],     32'h200);
      chk("t5_pc",     cons_pc[0],      32'h200);

      // 6: PC wrap, then reset while a response is outstanding
      do_reset();
      lat = 2;
      gnt_en = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      run_cycle();
      redirect_i = 1'b0; gnt_en = 1'b1;
      repeat (7) run_cycle();
      rst = 1'b1;
      repeat (2) run_cycle();
      rst = 1'b0;
      repeat (5) run_cycle();
      chk("t6_gnt_top",   gnt_addr[0],      32'hFFFF_FFFC);
      chk("t6_wrap_addr", obs_addr[4],      32'h0);
      chk("t6_pc_top",    cons_pc[0],       32'hFFFF_FFFC);
      chk("t6_rst_req",   32'(obs_req[9]),  32'd0);
      chk("t6_rst_valid", 32'(obs_valid[9]), 32'd0);
      chk("t6_post_req",  32'(obs_req[10]), 32'd1);
      chk("t6_post_addr", obs_addr[10],     32'h0);
      chk("t6_n_cons",    32'(n_cons),      32'd3);
      chk("t6_post_pc",   cons_pc[2],       32'h0);
      chk("t6_post_instr", cons_instr[2],   mem_word(32'h0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
